// File: rtl/load_align_unit_pkg.sv
// Shared load-path definitions: size codes, merge ops and the stage-A record.
package cpu_defs;

    // Widest supported data path; the stage-A record is sized for it.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    // Encoding equals {lwl, lwr} so the request bits can be cast directly.
    typedef enum logic [1:0] {
        MG_NONE = 2'd0,
        MG_LWR  = 2'd1,
        MG_LWL  = 2'd2,
        MG_BAD  = 2'd3
    } merge_e;

    typedef struct packed {
        logic [MAX_W-1:0] lane;    // addressed lane already at bit 0 (or word W for merges)
        size_e            size;
        logic             sgn;
        logic             err;
        merge_e           mop;
        logic [1:0]       k;       // byte offset inside word W for merges
        logic [31:0]      rt_old;
    } stage_a_t;

endpackage

// File: rtl/load_align_unit_if.sv
// Load-align bus: MEM-side beat in, WB-side result out, plus flush.
// Optional LOAD_UNALIGNED_EN adds the in_lwl/in_lwr merge requests.
interface load_align_unit_if #(
    parameter int DATA_W = 32
) ();
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [OFF_W-1:0]  in_off;
    logic [1:0]        in_size;
    logic              in_signed;
    logic [DATA_W-1:0] in_rt_old;
`ifdef LOAD_UNALIGNED_EN
    logic              in_lwl;
    logic              in_lwr;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_adel;

`ifdef LOAD_UNALIGNED_EN
    modport master (
        output flush, in_valid, in_data, in_off, in_size, in_signed, in_rt_old,
               in_lwl, in_lwr, out_ready,
        input  in_ready, out_valid, out_data, out_adel
    );
    modport slave (
        input  flush, in_valid, in_data, in_off, in_size, in_signed, in_rt_old,
               in_lwl, in_lwr, out_ready,
        output in_ready, out_valid, out_data, out_adel
    );
`else
    modport master (
        output flush, in_valid, in_data, in_off, in_size, in_signed, in_rt_old,
               out_ready,
        input  in_ready, out_valid, out_data, out_adel
    );
    modport slave (
        input  flush, in_valid, in_data, in_off, in_size, in_signed, in_rt_old,
               out_ready,
        output in_ready, out_valid, out_data, out_adel
    );
`endif

endinterface

// File: rtl/load_align_unit_load_ext.sv
// Combinational size/sign extension of the stage-A lane, plus the
// LWL/LWR merge when LOAD_UNALIGNED_EN is defined.
module load_ext
    import cpu_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  stage_a_t          sa,
    output logic [DATA_W-1:0] data,
    output logic              adel
);

    logic signed [DATA_W-1:0] lane_s;
    logic signed [DATA_W-1:0] shl;
    logic        [6:0]        sh;
    logic                     unused_sa;
`ifdef LOAD_UNALIGNED_EN
    logic        [31:0]       w;
    logic        [31:0]       rt;
    logic        [5:0]        kb;
    logic signed [31:0]       m32;
`endif

    assign unused_sa = ^sa;

    // Extension: push the loaded field to the top, then shift back arithmetically or logically.
    always_comb begin
        lane_s = sa.lane[DATA_W-1:0];
        sh     = 7'(DATA_W) - (7'd8 << sa.size);
        shl    = lane_s << sh;
        data   = sa.sgn ? DATA_W'(shl >>> sh) : DATA_W'(shl >> sh);
        adel   = 1'b0;
        if (sa.err) begin
            data = '0;
            adel = 1'b1;
        end
`ifdef LOAD_UNALIGNED_EN
        w   = sa.lane[31:0];
        rt  = sa.rt_old;
        kb  = {sa.k, 3'b000};
        m32 = '0;
        case (sa.mop)
            MG_LWL: begin
                m32  = (w << (6'd24 - kb)) | (rt & (32'hFFFF_FFFF >> (kb + 6'd8)));
                data = DATA_W'(m32);
                adel = 1'b0;
            end
            MG_LWR: begin
                m32  = (w >> kb) | (rt & ~(32'hFFFF_FFFF >> kb));
                data = DATA_W'(m32);
                adel = 1'b0;
            end
            MG_BAD: begin
                data = '0;
                adel = 1'b1;
            end
            default: ;
        endcase
`endif
    end

endmodule

// File: rtl/load_align_unit.sv
// Two-stage load alignment between MEM data return and WB write.
// Stage A selects the addressed lane and flags misalignment; stage B extends.
// Optional feature macro: LOAD_UNALIGNED_EN (LWL/LWR merge datapath).
module load_align_unit
    import cpu_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    load_align_unit_if.slave bus
);

    localparam int OFF_W = $clog2(DATA_W / 8);

    logic              live;
    logic              vld_p0;
    logic              vld_p1;
    logic              adv_a;
    logic              adv_b;
    logic              accept;
    stage_a_t          sa_d;
    stage_a_t          sa_p0;
    logic [DATA_W-1:0] data_p1;
    logic              adel_p1;
    logic [DATA_W-1:0] ext_data;
    logic              ext_adel;
    logic              unused_rt;
`ifdef LOAD_UNALIGNED_EN
    logic [OFF_W-1:0]  word_off;
`endif

    // Offset must be a multiple of the access size; dword does not exist on a 32-bit path.
    function automatic logic misaligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
        logic [3:0] mask;
        mask       = (4'd1 << size) - 4'd1;
        misaligned = ((4'(off) & mask) != 4'd0) || ((size == SZ_DWORD) && (DATA_W == 32));
    endfunction

    assign unused_rt = ^bus.in_rt_old;

    assign adv_b        = !vld_p1 || bus.out_ready;
    assign adv_a        = !vld_p0 || adv_b;
    assign bus.in_ready = live && adv_a;
    assign accept       = bus.in_valid && bus.in_ready;

    // Stage-A record for the beat on the input bus.
    always_comb begin
        sa_d      = '0;
        sa_d.size = size_e'(bus.in_size);
        sa_d.sgn  = bus.in_signed;
        sa_d.lane = MAX_W'(bus.in_data >> {bus.in_off, 3'b000});
        sa_d.err  = misaligned(bus.in_off, bus.in_size);
`ifdef LOAD_UNALIGNED_EN
        word_off    = bus.in_off & ~OFF_W'(3);
        sa_d.mop    = merge_e'({bus.in_lwl, bus.in_lwr});
        sa_d.k      = bus.in_off[1:0];
        sa_d.rt_old = bus.in_rt_old[31:0];
        if (sa_d.mop != MG_NONE) begin
            sa_d.lane = MAX_W'(bus.in_data >> {word_off, 3'b000});
            sa_d.err  = 1'b0;
        end
`endif
    end

    // Input becomes ready on the first edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) live <= 1'b0;
        else         live <= 1'b1;
    end

    // Stage valids: flush wins over any advance or accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (bus.flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (adv_b) vld_p1 <= vld_p0;
            if (adv_a) vld_p0 <= accept;
        end
    end

    // ---- stage A (p0): aligned lane and attributes ----
    always_ff @(posedge clk) begin
        if (accept) sa_p0 <= sa_d;
    end

    load_ext #(.DATA_W(DATA_W)) u_ext (
        .sa   (sa_p0),
        .data (ext_data),
        .adel (ext_adel)
    );

    // ---- stage B (p1): extended result, held while the consumer stalls ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_p1 <= '0;
            adel_p1 <= 1'b0;
        end else if (adv_b && vld_p0) begin
            data_p1 <= ext_data;
            adel_p1 <= ext_adel;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_adel  = adel_p1;

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised successor to the writeback load-extension logic.
- Takes raw memory read data plus byte offset and load type, selects the addressed lane, then sign- or zero-extends it.
- Flags misaligned or illegal accesses.
- Two-stage registered pipeline with valid/ready backpressure and flush; sits between the MEM-stage data return and the WB register-file write.

Parameters:
- DATA_W, 32, memory/register data width in bits; legal values 32 or 64.
- OFF_W, derived as log2(DATA_W/8), byte-offset width; local, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- in_data  in  DATA_W  raw memory read word.
- in_off  in  OFF_W  byte address low bits.
- in_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- in_signed  in  1  1=sign-extend, 0=zero-extend.
- in_rt_old  in  DATA_W  old destination value; used only with LOAD_UNALIGNED_EN.
- in_lwl, in_lwr  in  1 each  unaligned-merge ops; present only with LOAD_UNALIGNED_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  aligned and extended result.
- out_adel  out  1  address-error flag for this beat.

Behaviour:
- Reset: both stage valids 0; out_valid=0, out_data=0, out_adel=0. in_ready=1 one cycle after reset deassertion.
- Stage A, on accept (in_valid && in_ready):
  - registers the lane shifted right by 8*in_off, in_size, in_signed and the error flag;
  - error flag = (in_off mod 2^in_size != 0) or (in_size==3 && DATA_W==32).
- Stage B:
  - extends the low 8 << in_size bits to DATA_W, sign or zero per in_signed; dword passes through;
  - error beats drive out_data=0 and out_adel=1.
- Latency: exactly 2 cycles from accept to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Handshake:
  - B advances when !B.valid || out_ready.
  - A advances when !A.valid || B advances.
  - in_ready = !A.valid || B advances; this is combinational from out_ready, and in_ready does not depend on in_valid.
  - out_data and out_adel stay stable while out_valid && !out_ready.
- Flush: clears both valids next edge and beats presented that cycle are dropped; flush overrides simultaneous accept.
- Reset mid-operation: all in-flight beats are lost, with no partial output.
- Byte order is little-endian: lane i = bits [8i+7:8i].

Optional Feature:
- LOAD_UNALIGNED_EN defined:
  - in_lwl/in_lwr ports exist.
  - They operate on the 32-bit word lane W selected by in_off[OFF_W-1:2] (lane 0 when DATA_W=32), with k=in_off[1:0].
  - LWL: result bytes 3..3-k = W bytes k..0; lower bytes from in_rt_old.
  - LWR: result bytes 3-k..0 = W bytes 3..k; upper bytes from in_rt_old.
  - The 32-bit result is sign-extended to DATA_W. These ops never raise out_adel.
  - in_lwl && in_lwr together is illegal: out_adel=1, out_data=0.
- Undefined: the ports are absent, in_rt_old is ignored, and the merge datapath is not built.

Decomposition:
- Shared package (cpu_defs) holds:
  - size codes SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3;
  - the stage-A register struct (lane, size, signed, err, merge op, k, rt_old).
- One sub-module, load_ext: purely combinational size/sign extension and merge, instantiated in stage B.

Test Plan:
- DATA_W=32, in_data=0x8899AABB:
  - off=1, byte, signed -> out_data=0xFFFFFFAA after 2 cycles;
  - same beat unsigned -> 0x000000AA.
- DATA_W=32, half, off=2, signed, in_data=0x7F01_0000 -> 0x00007F01; off=1 half -> out_adel=1, out_data=0.
- DATA_W=64, dword, off=0, in_data=0x0123456789ABCDEF -> passes through unchanged.
- DATA_W=64, word, off=4, signed, high word 0x80000000 -> 0xFFFFFFFF80000000.
- Backpressure: stream 4 beats with out_ready held 0 for 3 cycles:
  - in_ready drops after 2 accepts;
  - outputs are held stable;
  - all 4 results appear in order with none lost or duplicated.
- Flush with both stages full and in_valid=1 -> next cycle out_valid=0, zero beats emitted.
- LOAD_UNALIGNED_EN, in_data=0x44332211, rt_old=0xAABBCCDD:
  - LWL k=1 -> 0x2211CCDD;
  - LWR k=1 -> 0xAA443322.
